// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory request/response bus between fetch and imem.
// The master holds req with addr until ack returns rdata.
interface pc_fetch_sequencer_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage PC owner: imem sequencing, one-delay-slot redirect,
// one-entry skid buffer for ID stalls, IF/ID register with PC+8.
module pc_fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   pc_fetch_sequencer_if.master bus,
   output logic        fd_valid,
   output logic [31:0] fd_pc,
   output logic [31:0] fd_instr,
   output logic [31:0] fd_pc8,
   output logic        addr_err
);

   typedef enum logic {
      FETCH,
      FULL
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] skid_pc;
   logic [31:0] skid_instr;
   logic [31:0] pend_pc;
   logic        pend_valid;

   logic        acc;
   logic        misal;
   logic        ack_f;
   logic        slot_free;
   logic [31:0] tgt;
   logic [31:0] next_pc;

   assign bus.imem_req  = (state == FETCH);
   assign bus.imem_addr = pc;

   assign acc       = redirect_valid & ~stall;
   assign misal     = |redirect_pc[1:0];
   assign tgt       = {redirect_pc[31:2], 2'b00};
   assign ack_f     = (state == FETCH) & bus.imem_ack;
   assign slot_free = ~stall | ~fd_valid;

   // A pending target belongs to the delay slot now being acked.
   always_comb begin
      next_pc = pc + 32'd4;
      if (pend_valid) begin
         next_pc = pend_pc;
      end else if (acc) begin
         next_pc = tgt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         fd_valid   <= 1'b0;
         fd_pc      <= 32'd0;
         fd_instr   <= 32'd0;
         fd_pc8     <= 32'd0;
         skid_pc    <= 32'd0;
         skid_instr <= 32'd0;
         pend_pc    <= 32'd0;
         pend_valid <= 1'b0;
         addr_err   <= 1'b0;
      end else begin
         if (acc && misal) begin
            addr_err <= 1'b1;
         end
         unique case (state)
            FETCH: begin
               if (ack_f) begin
                  pc <= next_pc;
                  if (slot_free) begin
                     fd_valid <= 1'b1;
                     fd_pc    <= pc;
                     fd_instr <= bus.imem_rdata;
                     fd_pc8   <= pc + 32'd8;
                  end else begin
                     skid_pc    <= pc;
                     skid_instr <= bus.imem_rdata;
                     state      <= FULL;
                  end
               end else if (!stall) begin
                  fd_valid <= 1'b0;
               end
               if (ack_f && pend_valid && !acc) begin
                  pend_valid <= 1'b0;
               end else if (acc && (!ack_f || pend_valid)) begin
                  pend_pc    <= tgt;
                  pend_valid <= 1'b1;
               end
            end
            FULL: begin
               // Skid already holds the delay slot, so a redirect
               // taken on release goes straight into pc.
               if (!stall) begin
                  fd_valid <= 1'b1;
                  fd_pc    <= skid_pc;
                  fd_instr <= skid_instr;
                  fd_pc8   <= skid_pc + 32'd8;
                  state    <= FETCH;
                  if (acc) begin
                     pc <= tgt;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer with a latency-configurable
// instruction memory and delivered/requested address monitors.
module tb_pc_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        fd_valid;
   logic [31:0] fd_pc;
   logic [31:0] fd_instr;
   logic [31:0] fd_pc8;
   logic        addr_err;

   int nvec = 0;
   int nerr = 0;
   int lat = 0;
   int cnt = 0;
   logic force_ack = 1'b0;

   logic [31:0] got[$];
   logic [31:0] reqs[$];

   pc_fetch_sequencer_if bus();

   pc_fetch_sequencer #(.RESET_PC(32'h0000_3000)) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .bus            (bus),
      .fd_valid       (fd_valid),
      .fd_pc          (fd_pc),
      .fd_instr       (fd_instr),
      .fd_pc8         (fd_pc8),
      .addr_err       (addr_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   always @(negedge clk) begin
      #1;
      bus.imem_ack   = force_ack | (bus.imem_req && cnt >= lat);
      bus.imem_rdata = mem_word(bus.imem_addr);
   end

   always @(posedge clk) begin
      if (reset || !bus.imem_req || bus.imem_ack) cnt <= 0;
      else cnt <= cnt + 1;
   end

   always @(posedge clk) begin
      if (!reset) begin
         if (fd_valid && !stall) got.push_back(fd_pc);
         if (bus.imem_req && bus.imem_ack) reqs.push_back(bus.imem_addr);
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      stall = 1'b0;
      redirect_valid = 1'b0;
      force_ack = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      got.delete();
      reqs.delete();
   endtask

   task automatic test_reset();
      lat = 0;
      do_reset();
      nvec++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3000) begin
         nerr++;
         $display("FAIL reset_req: req=%b addr=%h want 1/00003000",
                  bus.imem_req, bus.imem_addr);
      end
      nvec++;
      if (fd_valid !== 1'b0 || fd_pc !== 32'd0 || fd_instr !== 32'd0 ||
          fd_pc8 !== 32'd0 || addr_err !== 1'b0) begin
         nerr++;
         $display("FAIL reset_fd: v=%b pc=%h in=%h pc8=%h err=%b want 0",
                  fd_valid, fd_pc, fd_instr, fd_pc8, addr_err);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] e;
      lat = 0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         e = 32'h3000 + 32'(4 * i);
         nvec++;
         if (fd_valid !== 1'b1 || fd_pc !== e || fd_pc8 !== e + 32'd8 ||
             fd_instr !== mem_word(e)) begin
            nerr++;
            $display("FAIL seq_fd%0d: v=%b pc=%h pc8=%h in=%h want pc=%h",
                     i, fd_valid, fd_pc, fd_pc8, fd_instr, e);
         end
         nvec++;
         if (bus.imem_addr !== e + 32'd4) begin
            nerr++;
            $display("FAIL seq_addr%0d: got %h want %h",
                     i, bus.imem_addr, e + 32'd4);
         end
      end
   endtask

   task automatic test_redirect(input int lat_i, input logic [31:0] tgt,
                                input logic [31:0] exp_tgt,
                                input logic [31:0] exp_pc8,
                                input logic exp_pend);
      logic [31:0] exp[5];
      bit fired = 0;
      bit chk_pend = 0;
      bit seen = 0;
      int cyc = 0;
      exp = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, exp_tgt};
      lat = lat_i;
      do_reset();
      while (got.size() < 5 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (chk_pend) begin
            chk_pend = 0;
            nvec++;
            if (dut.pend_valid !== exp_pend) begin
               nerr++;
               $display("FAIL redir_pend %h: got %b want %b",
                        tgt, dut.pend_valid, exp_pend);
            end
         end
         if (fd_valid && fd_pc == exp_tgt && !seen) begin
            seen = 1;
            nvec++;
            if (fd_pc8 !== exp_pc8) begin
               nerr++;
               $display("FAIL redir_pc8 %h: got %h want %h",
                        tgt, fd_pc8, exp_pc8);
            end
         end
         if (!fired && fd_valid && fd_pc == 32'h3008) begin
            redirect_valid = 1'b1;
            redirect_pc = tgt;
            fired = 1;
            chk_pend = 1;
         end else begin
            redirect_valid = 1'b0;
         end
      end
      redirect_valid = 1'b0;
      nvec++;
      if (got.size() < 5 || !seen) begin
         nerr++;
         $display("FAIL redir_timeout %h: delivered %0d want 5",
                  tgt, got.size());
      end
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         nvec++;
         if (got[i] !== exp[i]) begin
            nerr++;
            $display("FAIL redir_seq %h [%0d]: got %h want %h",
                     tgt, i, got[i], exp[i]);
         end
      end
      foreach (reqs[i]) begin
         if (reqs[i] == 32'h3010) begin
            nerr++;
            $display("FAIL redir_no3010 %h: 00003010 fetched", tgt);
         end
      end
      nvec++;
   endtask

   task automatic test_misaligned();
      test_redirect(0, 32'h3102, 32'h3100, 32'h3108, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         nvec++;
         if (addr_err !== 1'b1) begin
            nerr++;
            $display("FAIL addr_err_sticky%0d: got %b want 1", i, addr_err);
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] exp[5];
      int cyc = 0;
      exp = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010};
      lat = 0;
      do_reset();
      while (!(fd_valid && fd_pc == 32'h3004) && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         nvec++;
         if (bus.imem_req !== 1'b0 || fd_valid !== 1'b1 ||
             fd_pc !== 32'h3004 || dut.skid_pc !== 32'h3008) begin
            nerr++;
            $display("FAIL stall_hold%0d: req=%b v=%b fd=%h skid=%h want 0/1/3004/3008",
                     i, bus.imem_req, fd_valid, fd_pc, dut.skid_pc);
         end
      end
      stall = 1'b0;
      @(negedge clk);
      nvec++;
      if (fd_pc !== 32'h3008 || fd_instr !== mem_word(32'h3008) ||
          bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300C) begin
         nerr++;
         $display("FAIL stall_release: fd=%h in=%h req=%b addr=%h want 3008/300C",
                  fd_pc, fd_instr, bus.imem_req, bus.imem_addr);
      end
      cyc = 0;
      while (got.size() < 5 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      nvec++;
      if (got.size() < 5) begin
         nerr++;
         $display("FAIL stall_timeout: delivered %0d want 5", got.size());
      end
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         nvec++;
         if (got[i] !== exp[i]) begin
            nerr++;
            $display("FAIL stall_seq[%0d]: got %h want %h", i, got[i], exp[i]);
         end
      end
   endtask

   task automatic test_reset_outstanding();
      int cyc = 0;
      lat = 3;
      do_reset();
      repeat (6) @(negedge clk);
      reset = 1'b1;
      force_ack = 1'b1;
      repeat (2) @(negedge clk);
      nvec++;
      if (fd_valid !== 1'b0 || fd_instr !== 32'd0 ||
          bus.imem_addr !== 32'h3000 || bus.imem_req !== 1'b1) begin
         nerr++;
         $display("FAIL rst_out_hold: v=%b in=%h addr=%h req=%b want 0/0/3000/1",
                  fd_valid, fd_instr, bus.imem_addr, bus.imem_req);
      end
      reset = 1'b0;
      force_ack = 1'b0;
      got.delete();
      reqs.delete();
      while (got.size() < 1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      nvec++;
      if (reqs.size() < 1 || reqs[0] !== 32'h3000) begin
         nerr++;
         $display("FAIL rst_out_first_req: n=%0d first=%h want 3000",
                  reqs.size(), reqs.size() > 0 ? reqs[0] : 32'hx);
      end
      nvec++;
      if (got.size() < 1 || got[0] !== 32'h3000) begin
         nerr++;
         $display("FAIL rst_out_first_fd: n=%0d first=%h want 3000",
                  got.size(), got.size() > 0 ? got[0] : 32'hx);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.imem_ack = 1'b0;
      bus.imem_rdata = 32'd0;
      test_reset();
      test_sequential();
      test_redirect(0, 32'h3100, 32'h3100, 32'h3108, 1'b0);
      test_redirect(3, 32'h3100, 32'h3100, 32'h3108, 1'b1);
      test_redirect(3, 32'h3400, 32'h3400, 32'h3408, 1'b1);
      test_redirect(0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0004, 1'b0);
      test_stall();
      test_misaligned();
      test_reset_outstanding();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
